// File: rtl/clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl
//   Per-unit clock-gating enable controller. Each gateable unit has its own
//   small FSM that drops the clk_gate enable after a run of idle cycles and,
//   on a wake condition, reasserts the enable and reports ready once the gated
//   clock has had time to settle.
//
// Ports
//   clk       in   processor clock (ungated)
//   rst_n     in   synchronous active-low reset, all units come up ON
//   active    in   [NUM_UNITS] per-unit "in use this cycle"
//   wake_req  in   [NUM_UNITS] per-unit explicit turn-on request
//   force_on  in   global override, holds or brings every unit on
//   enable    out  [NUM_UNITS] registered enable to the clk_gate cells
//   ready     out  [NUM_UNITS] registered "gated clock running and settled"
//
// Per-unit FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_ON   | clock running, enable=1 ready=1, idle_cnt counts idle cycles
//   ST_OFF  | clock gated,   enable=0 ready=0, waits for a wake condition
//   ST_WAKE | clock resumed, enable=1 ready=0, wake_cnt counts settle cycles
// ----------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int NUM_UNITS   = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_UNITS-1:0] active,
    input  logic [NUM_UNITS-1:0] wake_req,
    input  logic                 force_on,
    output logic [NUM_UNITS-1:0] enable,
    output logic [NUM_UNITS-1:0] ready
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    localparam logic [1:0] ST_ON   = 2'd0;
    localparam logic [1:0] ST_OFF  = 2'd1;
    localparam logic [1:0] ST_WAKE = 2'd2;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        logic [1:0]    state_q,    state_d;
        logic [IW-1:0] idle_cnt_q, idle_cnt_d;
        logic [WW-1:0] wake_cnt_q, wake_cnt_d;
        logic          enable_q,   enable_d;
        logic          ready_q,    ready_d;
        logic          wake_cond;

        assign wake_cond = active[g] | wake_req[g] | force_on;

        always_comb begin
            state_d    = state_q;
            idle_cnt_d = idle_cnt_q;
            wake_cnt_d = wake_cnt_q;
            enable_d   = enable_q;
            ready_d    = ready_q;
            case (state_q)
                ST_ON: begin
                    if (wake_cond) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_OFF;
                        idle_cnt_d = '0;
                        enable_d   = 1'b0;
                        ready_d    = 1'b0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (wake_cond) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = '0;
                        enable_d   = 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Inputs are deliberately ignored: a started wake always
                    // runs to completion so ready never glitches.
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_d    = ST_ON;
                        wake_cnt_d = '0;
                        idle_cnt_d = '0;
                        ready_d    = 1'b1;
                    end else begin
                        wake_cnt_d = wake_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a running clock.
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                    wake_cnt_d = '0;
                    enable_d   = 1'b1;
                    ready_d    = 1'b1;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q    <= ST_ON;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
                enable_q   <= 1'b1;
                ready_q    <= 1'b1;
            end else begin
                state_q    <= state_d;
                idle_cnt_q <= idle_cnt_d;
                wake_cnt_q <= wake_cnt_d;
                enable_q   <= enable_d;
                ready_q    <= ready_d;
            end
        end

        assign enable[g] = enable_q;
        assign ready[g]  = ready_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//   Two instances: a 2-unit IDLE=4/WAKE=2 controller driven by directed
//   sequences then random traffic, and a 3-unit IDLE=1/WAKE=1 controller
//   driven randomly. Every edge the reference model's expected outputs are
//   queued; a monitor pops and compares them after each edge.
// ----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

    typedef struct {
        bit on;        // running and settled
        bit waking;    // clock resumed, settling
        int idle_run;  // consecutive idle edges while running
        int wake_el;   // edges elapsed since the wake started
    } unit_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force_on;
    logic [1:0] act0, wk0, en0, rdy0;
    logic [2:0] act1, wk1, en1, rdy1;

    int total  = 0;
    int passed = 0;

    unit_t      m0 [2];
    unit_t      m1 [3];
    logic [3:0] q0 [$];
    logic [5:0] q1 [$];

    always #5 clk = ~clk;

    clk_gate_ctrl #(.NUM_UNITS(2), .IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .active(act0), .wake_req(wk0),
        .force_on(force_on), .enable(en0), .ready(rdy0)
    );

    clk_gate_ctrl #(.NUM_UNITS(3), .IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .active(act1), .wake_req(wk1),
        .force_on(force_on), .enable(en1), .ready(rdy1)
    );

    // Behavioural rule: a running unit turns off once idle_n idle edges have
    // accumulated; an off unit starts waking on any wake condition, and after
    // wake_n further edges it is running again.
    function automatic unit_t step(unit_t s, bit rst_b, bit w, int idle_n, int wake_n);
        unit_t n = s;
        if (!rst_b) begin
            n.on = 1'b1; n.waking = 1'b0; n.idle_run = 0; n.wake_el = 0;
        end else if (s.waking) begin
            n.wake_el = s.wake_el + 1;
            if (n.wake_el >= wake_n) begin
                n.waking = 1'b0; n.on = 1'b1; n.idle_run = 0; n.wake_el = 0;
            end
        end else if (s.on) begin
            n.idle_run = w ? 0 : s.idle_run + 1;
            if (n.idle_run >= idle_n) begin
                n.on = 1'b0; n.idle_run = 0;
            end
        end else if (w) begin
            n.waking = 1'b1; n.wake_el = 0;
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: update the model with the inputs sampled at this edge and
    // queue what the DUTs must show afterwards.
    task automatic cyc();
        logic [3:0] e0;
        logic [5:0] e1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m0[i] = step(m0[i], rst_n, act0[i] | wk0[i] | force_on, 4, 2);
            e0[2+i] = m0[i].on | m0[i].waking;
            e0[i]   = m0[i].on;
        end
        for (int i = 0; i < 3; i++) begin
            m1[i] = step(m1[i], rst_n, act1[i] | wk1[i] | force_on, 1, 1);
            e1[3+i] = m1[i].on | m1[i].waking;
            e1[i]   = m1[i].on;
        end
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
    endtask

    initial begin : monitor
        logic [3:0] x0;
        logic [5:0] x1;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x0 = q0.pop_front();
                check("sb_dut0 {en,rdy}", {28'd0, en0, rdy0}, {28'd0, x0});
            end
            if (q1.size() > 0) begin
                x1 = q1.pop_front();
                check("sb_dut1 {en,rdy}", {26'd0, en1, rdy1}, {26'd0, x1});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0; force_on = 1'b0;
        act0 = '0; wk0 = '0; act1 = '0; wk1 = '0;
        for (int i = 0; i < 2; i++) m0[i] = '{1'b1, 1'b0, 0, 0};
        for (int i = 0; i < 3; i++) m1[i] = '{1'b1, 1'b0, 0, 0};

        // reset held for two edges
        cyc();
        check("reset1 enable", en0, 2'b11);
        check("reset1 ready",  rdy0, 2'b11);
        cyc();
        check("reset2 enable", en0, 2'b11);
        check("reset2 ready",  rdy0, 2'b11);
        rst_n = 1'b1;

        // idle timeout: enable falls on the 4th idle edge
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("idle edge%0d enable0", k), en0[0],  (k < 4) ? 1 : 0);
            check($sformatf("idle edge%0d ready0",  k), rdy0[0], (k < 4) ? 1 : 0);
        end

        // one-cycle wake pulse on unit 0
        wk0 = 2'b01;
        cyc();
        check("wake e1 enable0", en0[0], 1);
        check("wake e1 ready0",  rdy0[0], 0);
        wk0 = 2'b00;
        cyc();
        check("wake e2 enable0", en0[0], 1);
        check("wake e2 ready0",  rdy0[0], 0);
        cyc();
        check("wake e3 ready0",  rdy0[0], 1);
        check("wake e3 unit1 off", en0[1], 0);

        // countdown restart: 3 idle, 1 active, then 4 more idle
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("restart pre-idle enable0", en0[0], 1);
        end
        act0 = 2'b01;
        cyc();
        check("restart active enable0", en0[0], 1);
        act0 = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("restart idle%0d enable0", k), en0[0], (k < 4) ? 1 : 0);
        end

        // force_on from both-off
        force_on = 1'b1;
        cyc();
        check("force e1 enable", en0, 2'b11);
        check("force e1 ready",  rdy0, 2'b00);
        cyc();
        check("force e2 ready",  rdy0, 2'b00);
        cyc();
        check("force e3 ready",  rdy0, 2'b11);
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("force hold enable", en0, 2'b11);
        end
        force_on = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("post-force timeout enable", en0, 2'b00);

        // reset mid-wake on unit 1
        wk0 = 2'b10;
        cyc();
        check("midwake enable1", en0[1], 1);
        check("midwake ready1",  rdy0[1], 0);
        wk0 = 2'b00;
        rst_n = 1'b0;
        cyc();
        check("midwake reset enable", en0, 2'b11);
        check("midwake reset ready",  rdy0, 2'b11);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("post-reset idle%0d enable1", k), en0[1], (k < 4) ? 1 : 0);
        end

        // random traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                act0[i] = ($urandom_range(0, 7) == 0);
                wk0[i]  = ($urandom_range(0, 15) == 0);
            end
            for (int i = 0; i < 3; i++) begin
                act1[i] = ($urandom_range(0, 3) == 0);
                wk1[i]  = ($urandom_range(0, 7) == 0);
            end
            force_on = ($urandom_range(0, 40) == 0);
            rst_n    = ($urandom_range(0, 250) != 0);
            cyc();
        end
        rst_n = 1'b1; force_on = 1'b0;
        act0 = '0; wk0 = '0; act1 = '0; wk1 = '0;

        repeat (3) @(negedge clk);
        check("scoreboard drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
